// File: rtl/spi_master_pkg.sv
// Shared constants, state encoding and frame helper for the SPI command master.
// State list depends on SPI_MASTER_CS_GAP_EN (adds the post-frame GAP state).
package spi_master_pkg;

    localparam int CMD_BITS           = 8;
    localparam int ADDR_BITS          = 8;
    localparam int PAYLOAD_BITS       = 8;
    localparam int MASTER_FRAME_WIDTH = CMD_BITS + ADDR_BITS + PAYLOAD_BITS;

    localparam logic CS_DEASSERT = 1'b1;

    localparam logic [CMD_BITS-1:0] CMD_NOP      = 8'h00;
    localparam logic [CMD_BITS-1:0] CMD_LED_SET  = 8'h01;
    localparam logic [CMD_BITS-1:0] CMD_LED_READ = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_CS_HOLD
`ifdef SPI_MASTER_CS_GAP_EN
        , ST_GAP
`endif
    } state_t;

    function automatic logic [MASTER_FRAME_WIDTH-1:0] build_frame(
        input logic [CMD_BITS-1:0]     cmd,
        input logic [ADDR_BITS-1:0]    addr,
        input logic [PAYLOAD_BITS-1:0] payload
    );
        return {cmd, addr, payload};
    endfunction

endpackage

// File: rtl/spi_master_if.sv
// Host-side request/response bus of the SPI command master.
// The master modport is the requester, the slave modport is the spi_master itself.
interface spi_master_if;
    import spi_master_pkg::*;

    logic                    i_start;
    logic [CMD_BITS-1:0]     i_cmd;
    logic [ADDR_BITS-1:0]    i_addr;
    logic [PAYLOAD_BITS-1:0] i_payload;
    logic                    o_busy;
    logic                    o_done;
    logic [PAYLOAD_BITS-1:0] o_rx_data;

    modport master (
        output i_start, i_cmd, i_addr, i_payload,
        input  o_busy, o_done, o_rx_data
    );

    modport slave (
        input  i_start, i_cmd, i_addr, i_payload,
        output o_busy, o_done, o_rx_data
    );

endinterface

// File: rtl/spi_sclk_gen.sv
// Half-period timer for the SPI clock: counts CLK_DIV sysclk cycles per half period
// while running and flags the last cycle of each half as a rise or fall strobe.
module spi_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic sysclk,
    input  logic rst,
    input  logic run,
    input  logic toggle_en,
    input  logic sclk_level,
    output logic half_end,
    output logic rise,
    output logic fall
);

    logic [7:0] half_cnt;

    assign half_end = run && (half_cnt == 8'(CLK_DIV - 1));
    assign rise     = half_end && toggle_en && !sclk_level;
    assign fall     = half_end && toggle_en &&  sclk_level;

    // The count restarts whenever the FSM is not in a timed state so every phase starts aligned.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            half_cnt <= '0;
        end else if (!run || half_end) begin
            half_cnt <= '0;
        end else begin
            half_cnt <= half_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 command master: sends a 24-bit {cmd, addr, payload} frame MSB first and
// captures the payload-phase byte from miso. SPI_MASTER_CS_GAP_EN enforces a CS-high gap.
module spi_master
    import spi_master_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic        sysclk,
    input  logic        rst,
    spi_master_if.slave bus,
    output logic        sclk,
    output logic        cs,
    output logic        mosi,
    input  logic        miso
);

    if (CLK_DIV < 4 || CLK_DIV > 255) begin : g_bad_clk_div
        $error("spi_master: CLK_DIV must be within 4..255");
    end
    if (GAP_CYCLES < 3 || GAP_CYCLES > 255) begin : g_bad_gap_cycles
        $error("spi_master: GAP_CYCLES must be within 3..255");
    end

    state_t state_q, next_state;

    logic                          run, toggle_en, half_end, rise, fall;
    logic                          load, cs_d, done_d;
    logic                          cs_q, done_q, sclk_q;
    logic                          miso_meta, miso_sync;
    logic [4:0]                    bit_cnt_q;
    logic [MASTER_FRAME_WIDTH-1:0] shift_q;
    logic [PAYLOAD_BITS-1:0]       rx_shift_q, rx_data_q;

`ifdef SPI_MASTER_CS_GAP_EN
    // The done cycle and the next accept cycle also keep cs high, so GAP covers the rest.
    localparam int GAP_LEN = GAP_CYCLES - 2;
    logic [7:0] gap_cnt_q;
`endif

    assign run       = (state_q == ST_CS_SETUP) || (state_q == ST_SHIFT) ||
                       ((state_q == ST_CS_HOLD) && !done_q);
    assign toggle_en = (state_q == ST_SHIFT);

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .sysclk     (sysclk),
        .rst        (rst),
        .run        (run),
        .toggle_en  (toggle_en),
        .sclk_level (sclk_q),
        .half_end   (half_end),
        .rise       (rise),
        .fall       (fall)
    );

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    // CS_HOLD spends one extra cycle with cs already high so o_done sits outside IDLE.
    always_comb begin
        next_state = state_q;
        cs_d       = cs_q;
        done_d     = 1'b0;
        load       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    next_state = ST_CS_SETUP;
                    cs_d       = ~CS_DEASSERT;
                    load       = 1'b1;
                end
            end
            ST_CS_SETUP: begin
                if (half_end) next_state = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (fall && (bit_cnt_q == 5'd0)) next_state = ST_CS_HOLD;
            end
            ST_CS_HOLD: begin
                if (done_q) begin
`ifdef SPI_MASTER_CS_GAP_EN
                    next_state = ST_GAP;
`else
                    next_state = ST_IDLE;
`endif
                end else if (half_end) begin
                    cs_d   = CS_DEASSERT;
                    done_d = 1'b1;
                end
            end
`ifdef SPI_MASTER_CS_GAP_EN
            ST_GAP: begin
                if (gap_cnt_q == 8'(GAP_LEN - 1)) next_state = ST_IDLE;
            end
`endif
            default: next_state = ST_IDLE;
        endcase
    end

    // Shifting and miso sampling both happen on the fall strobe, i.e. the last high cycle.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            cs_q       <= CS_DEASSERT;
            done_q     <= 1'b0;
            sclk_q     <= 1'b0;
            miso_meta  <= 1'b0;
            miso_sync  <= 1'b0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
        end else begin
            cs_q      <= cs_d;
            done_q    <= done_d;
            miso_meta <= miso;
            miso_sync <= miso_meta;
            if (rise) begin
                sclk_q <= 1'b1;
            end else if (fall) begin
                sclk_q <= 1'b0;
            end
            if (load) begin
                shift_q   <= build_frame(bus.i_cmd, bus.i_addr, bus.i_payload);
                bit_cnt_q <= 5'(MASTER_FRAME_WIDTH - 1);
            end else if (fall) begin
                shift_q    <= {shift_q[MASTER_FRAME_WIDTH-2:0], 1'b0};
                rx_shift_q <= {rx_shift_q[PAYLOAD_BITS-2:0], miso_sync};
                if (bit_cnt_q != 5'd0) bit_cnt_q <= bit_cnt_q - 5'd1;
            end
            if (done_d) rx_data_q <= rx_shift_q;
        end
    end

`ifdef SPI_MASTER_CS_GAP_EN
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            gap_cnt_q <= '0;
        end else if (state_q == ST_GAP) begin
            gap_cnt_q <= gap_cnt_q + 8'd1;
        end else begin
            gap_cnt_q <= '0;
        end
    end
`endif

    assign sclk          = sclk_q;
    assign cs            = cs_q;
    assign mosi          = shift_q[MASTER_FRAME_WIDTH-1];
    assign bus.o_done    = done_q;
    assign bus.o_rx_data = rx_data_q;
    assign bus.o_busy    = !rst && ((state_q != ST_IDLE) || bus.i_start);

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: bus monitors plus a mode-0 slave model supply the
// observed stream; expectations come from the frame rules. Honours SPI_MASTER_CS_GAP_EN.
module tb_spi_master;

    localparam int CLK_DIV    = 4;
    localparam int GAP_CYCLES = 8;
    localparam int CS_LOW_EXP = 50 * CLK_DIV;
`ifdef SPI_MASTER_CS_GAP_EN
    localparam int CS_GAP_EXP    = GAP_CYCLES;
    localparam int BUSY_FALL_EXP = GAP_CYCLES - 1;
`else
    localparam int CS_GAP_EXP    = 2;
    localparam int BUSY_FALL_EXP = 1;
`endif

    logic sysclk = 1'b0;
    logic rst    = 1'b0;
    logic sclk, cs, mosi;
    logic miso   = 1'b0;

    spi_master_if bus();

    spi_master #(
        .CLK_DIV    (CLK_DIV),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .sysclk (sysclk),
        .rst    (rst),
        .bus    (bus),
        .sclk   (sclk),
        .cs     (cs),
        .mosi   (mosi),
        .miso   (miso)
    );

    always #5 sysclk = ~sysclk;

    int vectors     = 0;
    int miscompares = 0;

    int          rise_total   = 0;
    int          done_total   = 0;
    int          cs_low_run   = 0;
    int          cs_high_run  = 0;
    int          last_cs_low  = 0;
    int          last_cs_high = 0;
    logic        prev_cs      = 1'b1;
    logic [23:0] mosi_cap     = '0;

    logic [23:0] slave_word  = '0;
    int          slv_idx     = 23;
    bit          slv_active  = 1'b0;

    bit          res_ok;
    logic [7:0]  res_rx;
    int          res_busy_fall;

    // Mode-0 receiver: capture mosi on every sclk rise while selected.
    always @(posedge sclk) begin
        if (!cs) begin
            mosi_cap = {mosi_cap[22:0], mosi};
            rise_total++;
        end
    end

    always @(negedge sysclk) begin
        if (!cs) begin
            if (prev_cs) begin
                last_cs_high = cs_high_run;
                cs_low_run   = 1;
            end else begin
                cs_low_run++;
            end
        end else begin
            if (!prev_cs) begin
                last_cs_low = cs_low_run;
                cs_high_run = 1;
            end else begin
                cs_high_run++;
            end
        end
        if (bus.o_done) done_total++;
        prev_cs = cs;
    end

    // Mode-0 slave: first bit on cs fall, next bit after each sclk fall.
    always @(cs or negedge sclk) begin
        if (cs) begin
            slv_active = 1'b0;
        end else if (!slv_active) begin
            slv_active = 1'b1;
            slv_idx    = 23;
        end else if (slv_idx > 0) begin
            slv_idx--;
        end
        miso = slave_word[slv_idx];
    end

    task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] p,
                              input logic [23:0] sw, input int inject_at);
        slave_word = sw;
        @(negedge sysclk);
        bus.i_cmd     = c;
        bus.i_addr    = a;
        bus.i_payload = p;
        bus.i_start   = 1'b1;
        @(negedge sysclk);
        bus.i_start   = 1'b0;
        bus.i_cmd     = 8'($urandom);
        bus.i_addr    = 8'($urandom);
        bus.i_payload = 8'($urandom);
        res_ok        = 1'b0;
        res_rx        = '0;
        res_busy_fall = 0;
        for (int i = 1; i <= 2000; i++) begin
            @(negedge sysclk);
            if (inject_at > 0) begin
                bus.i_start = (i == inject_at);
                if (i == inject_at) begin
                    bus.i_cmd     = 8'($urandom);
                    bus.i_addr    = 8'($urandom);
                    bus.i_payload = 8'($urandom);
                end
            end
            if (bus.o_done) begin
                res_ok = 1'b1;
                res_rx = bus.o_rx_data;
                break;
            end
        end
        bus.i_start = 1'b0;
        if (res_ok) begin
            for (int j = 1; j <= 64; j++) begin
                @(negedge sysclk);
                if (!bus.o_busy) begin
                    res_busy_fall = j;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        bus.i_start   = 1'b0;
        bus.i_cmd     = 8'($urandom);
        bus.i_addr    = 8'($urandom);
        bus.i_payload = 8'($urandom);
        #2 rst = 1'b1;
        repeat (3) @(negedge sysclk);
        vectors++; if (cs !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_cs got=%b exp=1", cs); end
        vectors++; if (sclk !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_sclk got=%b exp=0", sclk); end
        vectors++; if (mosi !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mosi got=%b exp=0", mosi); end
        vectors++; if (bus.o_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got=%b exp=0", bus.o_busy); end
        vectors++; if (bus.o_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done got=%b exp=0", bus.o_done); end
        vectors++; if (bus.o_rx_data !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_rx got=%h exp=00", bus.o_rx_data); end
        rst = 1'b0;
        repeat (4) @(negedge sysclk);
    endtask

    task automatic test_set_led();
        int r0, d0;
        logic [23:0] sw;
        sw = 24'($urandom);
        r0 = rise_total;
        d0 = done_total;
        send_frame(8'h01, 8'h03, 8'h14, sw, 0);
        vectors++; if (res_ok !== 1'b1) begin miscompares++; $display("[TB] FAIL set_led_timeout got=%b exp=1", res_ok); end
        vectors++; if (mosi_cap !== 24'h010314) begin miscompares++; $display("[TB] FAIL set_led_mosi got=%h exp=010314", mosi_cap); end
        vectors++; if (rise_total - r0 != 24) begin miscompares++; $display("[TB] FAIL set_led_rises got=%0d exp=24", rise_total - r0); end
        vectors++; if (last_cs_low != CS_LOW_EXP) begin miscompares++; $display("[TB] FAIL set_led_cs_low got=%0d exp=%0d", last_cs_low, CS_LOW_EXP); end
        vectors++; if (done_total - d0 != 1) begin miscompares++; $display("[TB] FAIL set_led_done_count got=%0d exp=1", done_total - d0); end
        vectors++; if (res_rx !== sw[7:0]) begin miscompares++; $display("[TB] FAIL set_led_rx got=%h exp=%h", res_rx, sw[7:0]); end
        vectors++; if (res_busy_fall != BUSY_FALL_EXP) begin miscompares++; $display("[TB] FAIL set_led_busy_fall got=%0d exp=%0d", res_busy_fall, BUSY_FALL_EXP); end
        repeat (10) @(negedge sysclk);
        vectors++; if (bus.o_rx_data !== sw[7:0]) begin miscompares++; $display("[TB] FAIL set_led_rx_hold got=%h exp=%h", bus.o_rx_data, sw[7:0]); end
    endtask

    task automatic test_read_led();
        logic [23:0] sw;
        logic [7:0]  pay;
        for (int k = 0; k < 2; k++) begin
            pay = 8'($urandom);
            sw  = {16'($urandom), (k == 0) ? 8'h01 : 8'h00};
            send_frame(8'h02, 8'h03, pay, sw, 0);
            vectors++; if (res_ok !== 1'b1) begin miscompares++; $display("[TB] FAIL read_led_timeout[%0d] got=%b exp=1", k, res_ok); end
            vectors++; if (mosi_cap !== {8'h02, 8'h03, pay}) begin miscompares++; $display("[TB] FAIL read_led_mosi[%0d] got=%h exp=%h", k, mosi_cap, {8'h02, 8'h03, pay}); end
            vectors++; if (res_rx !== sw[7:0]) begin miscompares++; $display("[TB] FAIL read_led_rx[%0d] got=%h exp=%h", k, res_rx, sw[7:0]); end
        end
    endtask

    task automatic test_random_frames();
        logic [7:0]  c, a, p;
        logic [23:0] sw;
        int r0, d0;
        for (int k = 0; k < 5; k++) begin
            c  = 8'($urandom);
            a  = 8'($urandom);
            p  = 8'($urandom);
            sw = 24'($urandom);
            r0 = rise_total;
            d0 = done_total;
            send_frame(c, a, p, sw, 0);
            vectors++; if (mosi_cap !== {c, a, p}) begin miscompares++; $display("[TB] FAIL random_mosi[%0d] got=%h exp=%h", k, mosi_cap, {c, a, p}); end
            vectors++; if (res_rx !== sw[7:0]) begin miscompares++; $display("[TB] FAIL random_rx[%0d] got=%h exp=%h", k, res_rx, sw[7:0]); end
            vectors++; if (rise_total - r0 != 24) begin miscompares++; $display("[TB] FAIL random_rises[%0d] got=%0d exp=24", k, rise_total - r0); end
            vectors++; if (done_total - d0 != 1) begin miscompares++; $display("[TB] FAIL random_done[%0d] got=%0d exp=1", k, done_total - d0); end
        end
    endtask

    task automatic test_busy_reject();
        int r0, d0;
        logic [23:0] sw;
        sw = 24'($urandom);
        r0 = rise_total;
        d0 = done_total;
        send_frame(8'hA5, 8'h3C, 8'h96, sw, 48);
        repeat (30) @(negedge sysclk);
        vectors++; if (res_ok !== 1'b1) begin miscompares++; $display("[TB] FAIL busy_timeout got=%b exp=1", res_ok); end
        vectors++; if (mosi_cap !== 24'hA53C96) begin miscompares++; $display("[TB] FAIL busy_mosi got=%h exp=a53c96", mosi_cap); end
        vectors++; if (done_total - d0 != 1) begin miscompares++; $display("[TB] FAIL busy_done_count got=%0d exp=1", done_total - d0); end
        vectors++; if (rise_total - r0 != 24) begin miscompares++; $display("[TB] FAIL busy_rises got=%0d exp=24", rise_total - r0); end
        vectors++; if (cs !== 1'b1) begin miscompares++; $display("[TB] FAIL busy_cs_idle got=%b exp=1", cs); end
    endtask

    task automatic test_reset_midframe();
        int r0, d0;
        bit ok;
        logic [7:0]  c, a, p;
        logic [23:0] sw;
        r0 = rise_total;
        d0 = done_total;
        slave_word = 24'($urandom);
        @(negedge sysclk);
        bus.i_cmd = 8'h5A; bus.i_addr = 8'hC3; bus.i_payload = 8'h0F; bus.i_start = 1'b1;
        @(negedge sysclk);
        bus.i_start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge sysclk);
            if (rise_total - r0 >= 10) begin ok = 1'b1; break; end
        end
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL midreset_rise_timeout got=%b exp=1", ok); end
        @(posedge sysclk);
        #1 rst = 1'b1;
        #1;
        vectors++; if (cs !== 1'b1) begin miscompares++; $display("[TB] FAIL midreset_cs got=%b exp=1", cs); end
        vectors++; if (sclk !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_sclk got=%b exp=0", sclk); end
        vectors++; if (bus.o_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_busy got=%b exp=0", bus.o_busy); end
        vectors++; if (bus.o_done !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_done got=%b exp=0", bus.o_done); end
        repeat (3) @(negedge sysclk);
        rst = 1'b0;
        repeat (20) @(negedge sysclk);
        vectors++; if (done_total - d0 != 0) begin miscompares++; $display("[TB] FAIL midreset_no_done got=%0d exp=0", done_total - d0); end
        c  = 8'($urandom);
        a  = 8'($urandom);
        p  = 8'($urandom);
        sw = 24'($urandom);
        r0 = rise_total;
        send_frame(c, a, p, sw, 0);
        vectors++; if (res_ok !== 1'b1) begin miscompares++; $display("[TB] FAIL midreset_next_timeout got=%b exp=1", res_ok); end
        vectors++; if (mosi_cap !== {c, a, p}) begin miscompares++; $display("[TB] FAIL midreset_next_mosi got=%h exp=%h", mosi_cap, {c, a, p}); end
        vectors++; if (rise_total - r0 != 24) begin miscompares++; $display("[TB] FAIL midreset_next_rises got=%0d exp=24", rise_total - r0); end
        vectors++; if (res_rx !== sw[7:0]) begin miscompares++; $display("[TB] FAIL midreset_next_rx got=%h exp=%h", res_rx, sw[7:0]); end
    endtask

    task automatic test_back_to_back();
        logic [23:0] f, sw;
        int r0;
        bit ok;
        f  = 24'($urandom);
        sw = 24'($urandom);
        slave_word = sw;
        @(negedge sysclk);
        bus.i_cmd = f[23:16]; bus.i_addr = f[15:8]; bus.i_payload = f[7:0];
        bus.i_start = 1'b1;
        r0 = rise_total;
        for (int n = 0; n < 3; n++) begin
            ok = 1'b0;
            for (int i = 0; i < 2000; i++) begin
                @(negedge sysclk);
                if (bus.o_done) begin ok = 1'b1; break; end
            end
            vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_timeout[%0d] got=%b exp=1", n, ok); end
            vectors++; if (mosi_cap !== f) begin miscompares++; $display("[TB] FAIL b2b_mosi[%0d] got=%h exp=%h", n, mosi_cap, f); end
            vectors++; if (rise_total - r0 != 24) begin miscompares++; $display("[TB] FAIL b2b_rises[%0d] got=%0d exp=24", n, rise_total - r0); end
            vectors++; if (bus.o_rx_data !== sw[7:0]) begin miscompares++; $display("[TB] FAIL b2b_rx[%0d] got=%h exp=%h", n, bus.o_rx_data, sw[7:0]); end
            if (n > 0) begin
                vectors++; if (last_cs_high != CS_GAP_EXP) begin miscompares++; $display("[TB] FAIL b2b_cs_gap[%0d] got=%0d exp=%0d", n, last_cs_high, CS_GAP_EXP); end
            end
            r0 = rise_total;
            if (n == 2) begin
                bus.i_start = 1'b0;
            end else begin
                f  = 24'($urandom);
                sw = 24'($urandom);
                slave_word = sw;
                bus.i_cmd = f[23:16]; bus.i_addr = f[15:8]; bus.i_payload = f[7:0];
            end
        end
        repeat (GAP_CYCLES + 4) @(negedge sysclk);
        vectors++; if (bus.o_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_final_busy got=%b exp=0", bus.o_busy); end
    endtask

    initial begin
        $display("[TB] spi_master bench, CLK_DIV=%0d", CLK_DIV);
        test_reset();
        test_set_led();
        test_read_led();
        test_random_frames();
        test_busy_reject();
        test_reset_midframe();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
